arbiter_puf_crp_engine: RTL and testbench
=========================================

// Module: arbiter_puf_crp_engine
// PURPOSE
//  Challenge-response controller for a bank of N_CH arbiter-PUF delay-line chains.
//  Accepts a challenge, drives it plus a launch pulse to the chains, samples each arbiter
//  over N_EVAL repeated launches, and majority-votes a stable response word per channel.
//  Flags non-unanimous channels and returns the result on a valid/ready output port.
//  Sits between the top-level pin wrapper and the mux delay-line / arbiter-DFF instances.
// PARAMETERS
//  C_LENGTH    8  challenge width = mux stages per chain
//  N_CH        8  parallel PUF chains (response bits)
//  N_EVAL      5  launches per challenge; must be odd and >=1 (elaboration error otherwise)
//  SETTLE_CYC  2  cycles launch held low, with challenge stable, before each launch
// PORTS
//  clk        in   1         system clock
//  rst_n      in   1         asynchronous active-low reset
//  start      in   1         request evaluation; accepted only in IDLE
//  chal_in    in   C_LENGTH  challenge, captured on accepted start
//  busy       out  1         high from accepted start until response handshake completes
//  chal_out   out  C_LENGTH  registered challenge driven to all chains
//  launch     out  1         pulse source driven into every delay line (ipulse)
//  arb_in     in   N_CH      raw arbiter DFF outputs (asynchronous to clk)
//  resp       out  N_CH      majority-voted response
//  unstable   out  N_CH      1 = channel's N_EVAL samples were not unanimous
//  resp_valid out  1         resp/unstable valid
//  resp_ready in   1         consumer accepts response
// BEHAVIOUR
//  - Reset (async, any state): FSM->IDLE; busy, launch, resp_valid, resp, unstable,
//    chal_out, eval counter and per-channel ones counters all 0.
//  - arb_in passes a 2-flop synchroniser per bit; only synchronised values are sampled.
//  - FSM: IDLE -> SETTLE -> LAUNCH -> SYNC -> (SETTLE | VOTE) -> OUT -> IDLE.
//  - IDLE: on start, chal_out<=chal_in, counters cleared, busy<=1, ->SETTLE.
//  - SETTLE: launch=0 for exactly SETTLE_CYC cycles, ->LAUNCH.
//  - LAUNCH: launch=1 for 1 cycle, ->SYNC.
//  - SYNC: launch stays 1 for 2 cycles. On the last SYNC cycle:
//    - ones_cnt[i] += synced arb[i]; eval_cnt++.
//    - ->VOTE if eval_cnt reaches N_EVAL, else ->SETTLE (launch drops to 0).
//  - Each evaluation costs SETTLE_CYC+3 cycles.
//  - VOTE (1 cycle):
//    - resp[i] = (ones_cnt[i] > N_EVAL/2).
//    - unstable[i] = (ones_cnt[i] != 0 && ones_cnt[i] != N_EVAL).
//    - ->OUT.
//  - OUT: resp_valid=1. resp, unstable and chal_out are held stable until resp_ready.
//    On resp_valid&&resp_ready: resp_valid<=0, busy<=0, ->IDLE. resp/unstable keep
//    their last values until the next VOTE.
//  - Latency: resp_valid rises N_EVAL*(SETTLE_CYC+3)+2 cycles after the start-accept edge.
//  - Counter widths: ones_cnt and eval_cnt are $clog2(N_EVAL+1) bits; they never wrap.
//  - Boundaries:
//    - start while busy: ignored, with no effect on chal_out.
//    - start in the same cycle as the OUT handshake: ignored; must be reasserted in IDLE.
//    - resp_ready without resp_valid: no effect.
//    - chal_in changes while busy: no effect.
//    - rst_n asserted mid-evaluation: launch falls immediately and any partial vote is discarded.
// CONFIGURATION
//  PUF_MAJORITY_VOTE_EN defined:
//    - N_EVAL launches with majority vote, as above.
//  PUF_MAJORITY_VOTE_EN undefined:
//    - Exactly one launch regardless of N_EVAL; resp = the single sample.
//    - unstable tied to 0.
//    - Latency SETTLE_CYC+5; ones counters not instantiated.
// TESTING (defaults, macro defined unless noted)
//  1) Reset: hold rst_n=0 with start=1 and arb_in=FF -> all outputs 0 and launch=0.
//     Release rst_n -> IDLE, busy=0.
//  2) start=1, chal_in=A5, arb_in=3C constant:
//     - chal_out=A5 one cycle after start.
//     - 5 launch pulses, each 3 cycles high preceded by 2 low.
//     - resp_valid at +27 cycles; resp=3C, unstable=00.
//  3) Per-launch arb_in bit0 sequence 1,1,0,1,0, other bits 0 -> resp=01, unstable=01.
//     Bit0 sequence 0,0,0,1,0 -> resp=00, unstable=01.
//  4) Hold resp_ready=0 for 10 cycles after valid -> resp and busy stay high.
//     start with chal_in=FF during the hold -> ignored, chal_out unchanged.
//     resp_ready=1 -> busy=0 next cycle.
//  5) Assert rst_n=0 during the 3rd launch, then release and start with chal_in=11, arb_in=00
//     -> fresh 5-evaluation run; resp=00, no leftover counts.
//  6) Macro undefined, arb_in=81 -> one launch; resp=81 at +7 cycles, unstable=00.

Source files
------------

// File: rtl/arbiter_puf_crp_engine.sv
// arbiter_puf_crp_engine: challenge-response controller for a bank of arbiter-PUF chains.
// Define PUF_MAJORITY_VOTE_EN for N_EVAL-launch majority voting; otherwise a single launch is taken.
module arbiter_puf_crp_engine #(
   parameter int C_LENGTH   = 8,
   parameter int N_CH       = 8,
   parameter int N_EVAL     = 5,
   parameter int SETTLE_CYC = 2
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                start,
   input  logic [C_LENGTH-1:0] chal_in,
   output logic                busy,
   output logic [C_LENGTH-1:0] chal_out,
   output logic                launch,
   input  logic [N_CH-1:0]     arb_in,
   output logic [N_CH-1:0]     resp,
   output logic [N_CH-1:0]     unstable,
   output logic                resp_valid,
   input  logic                resp_ready
);
   localparam int CW = $clog2(N_EVAL + 1);
   localparam int SW = $clog2(SETTLE_CYC + 2);
`ifdef PUF_MAJORITY_VOTE_EN
   localparam int N_RUN = N_EVAL;
`else
   localparam int N_RUN = 1;
`endif

   if (N_EVAL < 1 || N_EVAL % 2 == 0) begin : g_bad_n_eval
      $error("N_EVAL must be odd and >= 1");
   end

   typedef enum logic [2:0] {IDLE, SETTLE, LAUNCH, SYNC, VOTE, OUT} state_t;

   state_t          state, next;
   logic [SW-1:0]   cyc;
   logic [CW-1:0]   eval_cnt;
   logic [N_CH-1:0] arb_s1, arb_s2;
   logic            accept, settle_done, last_sync, handshake;

   assign accept      = state == IDLE && start;
   assign settle_done = state == SETTLE && cyc == SW'(SETTLE_CYC - 1);
   assign last_sync   = state == SYNC && cyc == SW'(1);
   assign handshake   = resp_valid && resp_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= next;
   end

   always_comb begin
      next = state;
      case (state)
         IDLE:    next = start ? SETTLE : IDLE;
         SETTLE:  next = settle_done ? LAUNCH : SETTLE;
         LAUNCH:  next = SYNC;
         SYNC:    next = !last_sync ? SYNC : (eval_cnt == CW'(N_RUN - 1)) ? VOTE : SETTLE;
         VOTE:    next = OUT;
         OUT:     next = handshake ? IDLE : OUT;
         default: next = IDLE;
      endcase
   end

   always_comb begin
      busy   = state != IDLE;
      launch = state == LAUNCH || state == SYNC;
   end

   // resp_valid is registered one cycle into OUT so resp is already settled when it rises
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cyc        <= '0;
         eval_cnt   <= '0;
         chal_out   <= '0;
         resp_valid <= 1'b0;
         arb_s1     <= '0;
         arb_s2     <= '0;
      end else begin
         arb_s1     <= arb_in;
         arb_s2     <= arb_s1;
         cyc        <= (next != state) ? '0 : cyc + SW'(1);
         resp_valid <= state == OUT && !handshake;
         if (accept) begin
            chal_out <= chal_in;
            eval_cnt <= '0;
         end else if (last_sync) begin
            eval_cnt <= eval_cnt + CW'(1);
         end
      end
   end

`ifdef PUF_MAJORITY_VOTE_EN
   logic [CW-1:0] ones_cnt [N_CH];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < N_CH; i++) ones_cnt[i] <= '0;
         resp     <= '0;
         unstable <= '0;
      end else begin
         for (int i = 0; i < N_CH; i++) begin
            if (accept) ones_cnt[i] <= '0;
            else if (last_sync) ones_cnt[i] <= ones_cnt[i] + CW'(arb_s2[i]);
            if (state == VOTE) begin
               resp[i]     <= ones_cnt[i] > CW'(N_EVAL / 2);
               unstable[i] <= ones_cnt[i] != '0 && ones_cnt[i] != CW'(N_EVAL);
            end
         end
      end
   end
`else
   logic [N_CH-1:0] sample;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sample <= '0;
         resp   <= '0;
      end else begin
         if (last_sync) sample <= arb_s2;
         if (state == VOTE) resp <= sample;
      end
   end

   assign unstable = '0;
`endif
endmodule

// File: tb/tb_arbiter_puf_crp_engine.sv
// tb_arbiter_puf_crp_engine: directed checks of the arbiter-PUF challenge-response engine.
// Expectations follow PUF_MAJORITY_VOTE_EN the same way the design does.
module tb_arbiter_puf_crp_engine;
`ifdef PUF_MAJORITY_VOTE_EN
   localparam bit MV = 1'b1;
`else
   localparam bit MV = 1'b0;
`endif
   localparam int LAT   = MV ? 27 : 7;
   localparam int HIGHS = MV ? 15 : 3;

   logic       clk = 1'b0, rst_n = 1'b0, start = 1'b0, resp_ready = 1'b0;
   logic [7:0] chal_in = '0, arb_in = '0;
   logic       busy, launch, resp_valid;
   logic [7:0] chal_out, resp, unstable;
   int         checks = 0, failures = 0;

   arbiter_puf_crp_engine dut (
      .clk(clk), .rst_n(rst_n), .start(start), .chal_in(chal_in), .busy(busy),
      .chal_out(chal_out), .launch(launch), .arb_in(arb_in), .resp(resp),
      .unstable(unstable), .resp_valid(resp_valid), .resp_ready(resp_ready)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // seq holds the per-launch arb_in values, launch 0 in the low byte
   task automatic run(input logic [7:0] chal, input logic [39:0] seq,
                      input logic [7:0] er, input logic [7:0] eu, input bit ack);
      int   cyc = 0, highs = 0, k = 0;
      logic prev = 1'b0;
      arb_in  = seq[7:0];
      chal_in = chal;
      start   = 1'b1;
      tick;
      start = 1'b0;
      check("chal_out", chal_out, chal);
      while (!resp_valid && cyc < 200) begin
         tick;
         cyc++;
         if (launch) highs++;
         if (prev && !launch && k < 4) begin
            k++;
            arb_in = seq[8*k +: 8];
         end
         prev = launch;
      end
      check("latency", cyc, LAT);
      check("launch_high", highs, HIGHS);
      check("resp", resp, er);
      check("unstable", unstable, eu);
      check("busy_out", busy, 1);
      if (ack) begin
         resp_ready = 1'b1;
         tick;
         resp_ready = 1'b0;
         check("busy_ack", busy, 0);
         check("valid_ack", resp_valid, 0);
         check("resp_hold", resp, er);
      end
   endtask

   initial begin
      int n = 0, cyc = 0;
      logic prev = 1'b0;
      start  = 1'b1;
      arb_in = 8'hFF;
      chal_in = 8'hAA;
      repeat (3) @(posedge clk);
      #1;
      check("rst_busy", busy, 0);
      check("rst_launch", launch, 0);
      check("rst_valid", resp_valid, 0);
      check("rst_resp", resp, 0);
      check("rst_unstable", unstable, 0);
      check("rst_chal", chal_out, 0);
      start = 1'b0;
      @(negedge clk) rst_n = 1'b1;
      tick;
      tick;
      check("idle_busy", busy, 0);
      resp_ready = 1'b1;
      tick;
      tick;
      resp_ready = 1'b0;
      check("ready_idle_busy", busy, 0);
      check("ready_idle_valid", resp_valid, 0);

      run(8'hA5, 40'h3C_3C_3C_3C_3C, 8'h3C, 8'h00, 1'b1);
      run(8'h01, 40'h00_01_00_01_01, 8'h01, MV ? 8'h01 : 8'h00, 1'b1);
      run(8'h02, 40'h00_01_00_00_00, 8'h00, MV ? 8'h01 : 8'h00, 1'b1);
      run(8'h03, 40'h00_FF_0F_F0_F0, 8'hF0, MV ? 8'hFF : 8'h00, 1'b1);

      run(8'h5A, 40'h00_01_00_01_01, 8'h01, MV ? 8'h01 : 8'h00, 1'b0);
      for (int i = 0; i < 10; i++) begin
         chal_in = 8'hFF;
         start   = (i == 3);
         tick;
      end
      start = 1'b0;
      check("hold_valid", resp_valid, 1);
      check("hold_busy", busy, 1);
      check("hold_chal", chal_out, 8'h5A);
      check("hold_resp", resp, 8'h01);
      start      = 1'b1;
      chal_in    = 8'hC3;
      resp_ready = 1'b1;
      tick;
      start      = 1'b0;
      resp_ready = 1'b0;
      check("hs_busy", busy, 0);
      check("hs_chal", chal_out, 8'h5A);
      tick;
      check("hs_start_ignored", busy, 0);

      arb_in  = 8'hFF;
      chal_in = 8'h22;
      start   = 1'b1;
      tick;
      start = 1'b0;
      while (n < (MV ? 3 : 1) && cyc < 200) begin
         tick;
         cyc++;
         if (launch && !prev) n++;
         prev = launch;
      end
      check("abort_launches", n, MV ? 3 : 1);
      #2 rst_n = 1'b0;
      #1;
      check("abort_launch", launch, 0);
      check("abort_busy", busy, 0);
      check("abort_chal", chal_out, 0);
      @(negedge clk) rst_n = 1'b1;
      tick;
      run(8'h11, 40'h00_00_00_00_00, 8'h00, 8'h00, 1'b1);
      run(8'h81, 40'h81_81_81_81_81, 8'h81, 8'h00, 1'b1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end
endmodule
